// File: rtl/rot_cmd_fifo.sv
// Command FIFO feeding the combinational right rotator; resolves relative amounts on push.
// Optional same-cycle empty-FIFO bypass: define ROT_CMD_FIFO_BYPASS_EN.
module rot_cmd_fifo #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_a,
  input  logic [$clog2(N)-1:0]       in_b,
  input  logic                       in_rel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_a,
  output logic [$clog2(N)-1:0]       out_b,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned BW = $clog2(N);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [N-1:0]  mem_a [DEPTH];
  logic [BW-1:0] mem_b [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [BW-1:0] acc;
  logic [BW-1:0] b_abs;
  logic          push;
  logic          push_mem;
  logic          pop_mem;
  logic          not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = !rst && (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign b_abs     = in_rel ? BW'(acc + in_b) : in_b;
  assign pop_mem   = not_empty && out_ready;

`ifdef ROT_CMD_FIFO_BYPASS_EN
  logic bypass;

  // An empty FIFO forwards the incoming command; it is only stored if not taken now.
  assign bypass    = in_valid && !rst && (count == '0);
  assign out_valid = not_empty || bypass;
  assign out_a     = bypass ? in_a  : mem_a[rd_ptr];
  assign out_b     = bypass ? b_abs : mem_b[rd_ptr];
  assign push_mem  = push && !(bypass && out_ready);
`else
  assign out_valid = not_empty;
  assign out_a     = mem_a[rd_ptr];
  assign out_b     = mem_b[rd_ptr];
  assign push_mem  = push;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      acc    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (push) begin
        acc <= b_abs;
      end
      if (push_mem) begin
        mem_a[wr_ptr] <= in_a;
        mem_b[wr_ptr] <= b_abs;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop_mem) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_mem, pop_mem})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
